// File: rtl/hs_npu_pkg.sv
// Shared types and defaults for the NPU systolic-array feeder.
// Operand/sum widths, the feeder state encoding and counter sizing live here.
package hs_npu_pkg;

    localparam int LANES_DEF        = 8;
    localparam int OP_W             = 16;
    localparam int SUM_W            = 32;
    localparam int FLUSH_CYCLES_DEF = 16;

    typedef logic signed [OP_W-1:0]  op_t;
    typedef logic signed [SUM_W-1:0] sum_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2
    } feeder_state_e;

    // Width of a down-counter that must hold n-1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hs_npu_systolic_feeder_if.sv
// Producer-side handshake plus the skewed array-side feed of the systolic feeder.
// The master modport is the producer/observer; the slave modport is the feeder.
interface hs_npu_systolic_feeder_if
    import hs_npu_pkg::*;
#(
    parameter int LANES = LANES_DEF
) ();

    logic in_valid;
    logic in_ready;
    op_t  in_a    [LANES];
    op_t  in_b    [LANES];
    sum_t in_bias [LANES];
    logic in_last;

    op_t  matrixA [LANES];
    op_t  matrixB [LANES];
    sum_t sum_out [LANES];
    logic enable_out;
    logic done_out;

    modport master (
        output in_valid, in_a, in_b, in_bias, in_last,
        input  in_ready, matrixA, matrixB, sum_out, enable_out, done_out
    );

    modport slave (
        input  in_valid, in_a, in_b, in_bias, in_last,
        output in_ready, matrixA, matrixB, sum_out, enable_out, done_out
    );

endinterface

// File: rtl/hs_npu_skew_line.sv
// Fixed-depth shift chain that delays one lane of operand data by DEPTH advances.
// Shifts only when shift_en_i is set; clr_i zeroes every stage at tile end.
module hs_npu_skew_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    // NOTE: every stage is a discrete flop rather than a RAM, so clearing all of
    // them on reset is legal and guarantees the array only ever sees zeros first.
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else if (shift_en_i) begin
            stage_q[0] <= din_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign dout_o = stage_q[DEPTH-1];

endmodule

// File: rtl/hs_npu_systolic_feeder.sv
// Accepts operand row vectors, skews them lane-by-lane into a systolic array,
// holds the per-lane bias for the tile and flushes zeros until the array drains.
module hs_npu_systolic_feeder
    import hs_npu_pkg::*;
#(
    parameter int LANES        = LANES_DEF,
    parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    hs_npu_systolic_feeder_if.slave   bus
);

    localparam int                CNT_W    = cnt_width(FLUSH_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

    feeder_state_e    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    sum_t             sum_q [LANES];
    sum_t             sum_d [LANES];
    logic             en_q, done_q;

    logic             ready;
    logic             accept;
    logic             advance;
    logic             tile_done;

    op_t              a_feed [LANES];
    op_t              b_feed [LANES];
    op_t              a_out  [LANES];
    op_t              b_out  [LANES];

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sum_d     = sum_q;
        advance   = 1'b0;
        tile_done = 1'b0;
        ready     = !rst && (state_q != ST_FLUSH);
        accept    = bus.in_valid && ready;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    advance = 1'b1;
                    sum_d   = bus.in_bias;
                    if (bus.in_last) begin
                        state_d = ST_FLUSH;
                        cnt_d   = CNT_LOAD;
                    end else begin
                        state_d = ST_STREAM;
                    end
                end
            end
            ST_STREAM: begin
                if (accept) begin
                    advance = 1'b1;
                    if (bus.in_last) begin
                        state_d = ST_FLUSH;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            ST_FLUSH: begin
                advance = 1'b1;
                if (cnt_q == '0) begin
                    state_d   = ST_IDLE;
                    tile_done = 1'b1;
                    sum_d     = '{default: '0};
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sum_q   <= '{default: '0};
            en_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            en_q    <= advance;
            done_q  <= tile_done;
        end
    end

    // Lane k is k+1 stages deep; flushing injects zeros instead of producer data.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign a_feed[k] = (state_q == ST_FLUSH) ? '0 : bus.in_a[k];
        assign b_feed[k] = (state_q == ST_FLUSH) ? '0 : bus.in_b[k];

        hs_npu_skew_line #(.DEPTH(k + 1), .WIDTH(OP_W)) u_skew_a (
            .clk        (clk),
            .rst        (rst),
            .shift_en_i (advance),
            .clr_i      (tile_done),
            .din_i      (a_feed[k]),
            .dout_o     (a_out[k])
        );

        hs_npu_skew_line #(.DEPTH(k + 1), .WIDTH(OP_W)) u_skew_b (
            .clk        (clk),
            .rst        (rst),
            .shift_en_i (advance),
            .clr_i      (tile_done),
            .din_i      (b_feed[k]),
            .dout_o     (b_out[k])
        );
    end

    assign bus.in_ready   = ready;
    assign bus.matrixA    = a_out;
    assign bus.matrixB    = b_out;
    assign bus.sum_out    = sum_q;
    assign bus.enable_out = en_q;
    assign bus.done_out   = done_q;

endmodule

// File: tb/tb_hs_npu_systolic_feeder.sv
// Scoreboard bench for the systolic feeder: the driver pushes one expected
// array-side record per advance, the monitor pops one per enable_out cycle.
module tb_hs_npu_systolic_feeder;
    import hs_npu_pkg::*;

    localparam int LANES = LANES_DEF;
    localparam int FLUSH = FLUSH_CYCLES_DEF;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    hs_npu_systolic_feeder_if #(.LANES(LANES)) bus ();

    hs_npu_systolic_feeder #(.LANES(LANES), .FLUSH_CYCLES(FLUSH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        op_t a [LANES];
        op_t b [LANES];
    } vec_t;

    typedef struct {
        op_t  a    [LANES];
        op_t  b    [LANES];
        sum_t bias [LANES];
        bit   last;
    } beat_t;

    typedef struct {
        op_t  a [LANES];
        op_t  b [LANES];
        sum_t s [LANES];
        bit   done;
    } rec_t;

    rec_t  exp_q [$];
    vec_t  hist  [$];
    rec_t  held;
    rec_t  mon_rec;
    sum_t  cur_bias [LANES];
    bit    in_tile;
    bit    mon_on;
    int    chk_cnt;
    int    pass_cnt;

    task automatic check(input bit ok, input string name, input longint act, input longint req);
        chk_cnt++;
        if (ok) pass_cnt++;
        else $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    endtask

    function automatic vec_t zero_vec();
        vec_t v;
        for (int k = 0; k < LANES; k++) begin
            v.a[k] = '0;
            v.b[k] = '0;
        end
        return v;
    endfunction

    function automatic rec_t zero_rec();
        rec_t r;
        for (int k = 0; k < LANES; k++) begin
            r.a[k] = '0;
            r.b[k] = '0;
            r.s[k] = '0;
        end
        r.done = 1'b0;
        return r;
    endfunction

    // Reference: the array sees, on lane k, the vector injected k advances
    // before the most recent one (zero if none); sums are the tile's first bias.
    function automatic void model_advance(input vec_t v, input bit done);
        rec_t r;
        hist.push_back(v);
        if (hist.size() > LANES) void'(hist.pop_front());
        for (int k = 0; k < LANES; k++) begin
            if (hist.size() > k) begin
                r.a[k] = hist[hist.size() - 1 - k].a[k];
                r.b[k] = hist[hist.size() - 1 - k].b[k];
            end else begin
                r.a[k] = '0;
                r.b[k] = '0;
            end
            r.s[k] = done ? '0 : cur_bias[k];
        end
        r.done = done;
        exp_q.push_back(r);
    endfunction

    function automatic beat_t rand_beat(input bit last);
        beat_t bt;
        for (int k = 0; k < LANES; k++) begin
            bt.a[k]    = op_t'($urandom);
            bt.b[k]    = op_t'($urandom);
            bt.bias[k] = sum_t'($urandom);
        end
        bt.last = last;
        return bt;
    endfunction

    task automatic drive_beat(input beat_t bt);
        vec_t v;
        @(negedge clk);
        check(bus.in_ready === 1'b1, "in_ready_open", longint'(bus.in_ready), 1);
        bus.in_valid = 1'b1;
        bus.in_a     = bt.a;
        bus.in_b     = bt.b;
        bus.in_bias  = bt.bias;
        bus.in_last  = bt.last;
        @(posedge clk);
        if (!in_tile) begin
            cur_bias = bt.bias;
            in_tile  = 1'b1;
        end
        v.a = bt.a;
        v.b = bt.b;
        model_advance(v, 1'b0);
        if (bt.last) begin
            for (int i = 0; i < FLUSH; i++) model_advance(zero_vec(), i == FLUSH - 1);
            in_tile = 1'b0;
        end
    endtask

    // Producer keeps pushing junk while the feeder drains; it must be refused.
    task automatic flush_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check(bus.in_ready === 1'b0, "in_ready_flush", longint'(bus.in_ready), 0);
            bus.in_valid = 1'b1;
            for (int k = 0; k < LANES; k++) begin
                bus.in_a[k]    = op_t'(16'h7FFF);
                bus.in_b[k]    = op_t'(16'h7FFF);
                bus.in_bias[k] = sum_t'($urandom);
            end
            bus.in_last = 1'($urandom_range(0, 1));
            @(posedge clk);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            @(posedge clk);
        end
    endtask

    task automatic compare_out(input rec_t r, input string tag);
        int ia, ib, is, ja, jb, js;
        ia = -1; ib = -1; is = -1;
        for (int k = 0; k < LANES; k++) begin
            if (ia < 0 && bus.matrixA[k] !== r.a[k]) ia = k;
            if (ib < 0 && bus.matrixB[k] !== r.b[k]) ib = k;
            if (is < 0 && bus.sum_out[k] !== r.s[k]) is = k;
        end
        ja = (ia < 0) ? 0 : ia;
        jb = (ib < 0) ? 0 : ib;
        js = (is < 0) ? 0 : is;
        check(ia < 0, $sformatf("%s_matrixA[%0d]", tag, ja), longint'(bus.matrixA[ja]), longint'(r.a[ja]));
        check(ib < 0, $sformatf("%s_matrixB[%0d]", tag, jb), longint'(bus.matrixB[jb]), longint'(r.b[jb]));
        check(is < 0, $sformatf("%s_sum_out[%0d]", tag, js), longint'(bus.sum_out[js]), longint'(r.s[js]));
    endtask

    // Monitor: each enable_out cycle consumes one record; otherwise outputs hold.
    always @(negedge clk) begin
        if (mon_on) begin
            if (bus.enable_out === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_enable", longint'(bus.enable_out), 0);
                end else begin
                    mon_rec = exp_q.pop_front();
                    compare_out(mon_rec, "adv");
                    check(bus.done_out === mon_rec.done, "done_out", longint'(bus.done_out), longint'(mon_rec.done));
                    held = mon_rec;
                end
            end else begin
                check(bus.enable_out === 1'b0, "enable_out_known", longint'(bus.enable_out), 0);
                check(bus.done_out === 1'b0, "done_without_enable", longint'(bus.done_out), 0);
                compare_out(held, "hold");
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time %0t exceeded, required finish earlier", $time);
        $fatal(1);
    end

    initial begin
        beat_t bt;
        int    len;

        chk_cnt      = 0;
        pass_cnt     = 0;
        in_tile      = 1'b0;
        mon_on       = 1'b0;
        held         = zero_rec();
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            bus.in_a[k]    = '0;
            bus.in_b[k]    = '0;
            bus.in_bias[k] = '0;
        end

        // Reset state.
        repeat (2) @(posedge clk);
        mon_on = 1'b1;
        @(negedge clk);
        check(bus.in_ready === 1'b0, "in_ready_reset", longint'(bus.in_ready), 0);
        rst = 1'b0;

        // Single-beat tile with known values.
        for (int k = 0; k < LANES; k++) begin
            bt.a[k]    = op_t'(k + 1);
            bt.b[k]    = op_t'(10 * (k + 1));
            bt.bias[k] = sum_t'(5);
        end
        bt.last = 1'b1;
        drive_beat(bt);
        flush_cycles(FLUSH);
        idle(2);

        // Eight beats carrying their own index, bias changes after the first beat.
        for (int j = 0; j < 8; j++) begin
            bt = rand_beat(j == 7);
            for (int k = 0; k < LANES; k++) bt.a[k] = op_t'(j + 1);
            drive_beat(bt);
        end
        flush_cycles(FLUSH);
        idle(1);

        // Producer bubble of three cycles mid-stream.
        for (int j = 0; j < 6; j++) begin
            drive_beat(rand_beat(j == 5));
            if (j == 2) idle(3);
        end
        flush_cycles(FLUSH);

        // Back-to-back tiles: second tile presented in the done_out cycle.
        for (int j = 0; j < 3; j++) drive_beat(rand_beat(j == 2));
        flush_cycles(FLUSH);
        for (int j = 0; j < 2; j++) drive_beat(rand_beat(j == 1));
        flush_cycles(FLUSH);
        idle(2);

        // Reset while the flush counter reads 5 aborts the tile silently.
        drive_beat(rand_beat(1'b0));
        drive_beat(rand_beat(1'b1));
        flush_cycles(FLUSH - 1 - 5);
        @(negedge clk);
        check(bus.in_ready === 1'b0, "in_ready_flush_at_5", longint'(bus.in_ready), 0);
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        exp_q.delete();
        hist.delete();
        in_tile = 1'b0;
        held    = zero_rec();
        @(negedge clk);
        check(bus.in_ready === 1'b0, "in_ready_mid_reset", longint'(bus.in_ready), 0);
        rst = 1'b0;
        for (int j = 0; j < 4; j++) drive_beat(rand_beat(j == 3));
        flush_cycles(FLUSH);

        // Randomised tiles with random bubbles and gaps.
        for (int t = 0; t < 12; t++) begin
            len = $urandom_range(1, 10);
            for (int j = 0; j < len; j++) begin
                drive_beat(rand_beat(j == len - 1));
                if (j != len - 1 && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            end
            flush_cycles(FLUSH);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 4));
        end

        idle(3);
        check(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
